mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-003 SHALL have parameter BLOCK_SIZE, default 16, words per block (power of 2).
REQ-004 SHALL have parameter MEM_BLOCKS, default 256, blocks stored (power of 2).
REQ-005 SHALL have parameter MISS_LATENCY, default 8, request-to-response cycles for a closed-row access.
REQ-006 SHALL have parameter HIT_LATENCY, default 2, request-to-response cycles for an open-row access; 1 <= HIT_LATENCY <= MISS_LATENCY.
REQ-007 SHALL have port clk  input  1  clock, rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port mem_addr  input  ADDR_WIDTH  block request address from cache.
REQ-010 SHALL have port mem_data_in  input  BLOCK_SIZE x DATA_WIDTH  write block from cache.
REQ-011 SHALL have port mem_read  input  1  read request, held by cache until completion.
REQ-012 SHALL have port mem_write  input  1  write request, held by cache until completion.
REQ-013 SHALL have port mem_data_out  output  BLOCK_SIZE x DATA_WIDTH  read block to cache.
REQ-014 SHALL have port mem_ready  output  1  one-cycle completion pulse, closed-row access.
REQ-015 SHALL have port mem_hit  output  1  one-cycle completion pulse, open-row access.
REQ-016 SHALL have port access_count  output  16  completed accesses, saturating.
REQ-017 SHALL have port row_hit_count  output  16  completed open-row accesses, saturating.

Function
REQ-018 SHALL use block index = mem_addr[log2(BLOCK_SIZE)+log2(MEM_BLOCKS)-1 : log2(BLOCK_SIZE)]; offset and upper bits ignored.
REQ-019 SHALL implement FSM IDLE, WAIT, RESP, RECOVER; IDLE -> WAIT when mem_read or mem_write high, else stay.
REQ-020 SHALL capture index, operation, mem_data_in on the IDLE->WAIT edge; later input changes ignored until RECOVER exits.
REQ-021 SHALL treat simultaneous mem_read and mem_write as a write.
REQ-022 SHALL classify the request as open-row when open-row valid and captured index equals open-row index; latency L = HIT_LATENCY, else MISS_LATENCY.
REQ-023 SHALL load countdown with L-1 on capture, decrement in WAIT, enter RESP when it reaches 0; response pulse in cycle exactly L after the request-visible cycle 0.
REQ-024 SHALL in RESP assert exactly one of mem_hit (open-row) or mem_ready (closed-row) for one cycle, never both.
REQ-025 SHALL for reads drive mem_data_out with array[index] in the RESP cycle and hold it until the next read response.
REQ-026 SHALL for writes update array[index] with the captured block on the RESP edge; mem_data_out unchanged.
REQ-027 SHALL on each RESP set open-row index to captured index and open-row valid to 1.
REQ-028 SHALL on each RESP increment access_count, plus row_hit_count if open-row; both saturate at 16'hFFFF.
REQ-029 SHALL spend exactly one cycle in RECOVER ignoring requests, then return to IDLE.

Reset
REQ-030 SHALL on rst_n low asynchronously force state IDLE, mem_ready 0, mem_hit 0, mem_data_out 0, counters 0, open-row valid 0, countdown 0.
REQ-031 SHALL leave array contents unchanged by reset; in-flight access abandoned, no write performed, no pulse issued.

Structure
REQ-032 SHALL place the state enum and default parameter constants in shared package mem_pkg.
REQ-033 SHALL instantiate sub-module mem_array (synchronous-write, combinational-read block storage, MEM_BLOCKS x BLOCK_SIZE x DATA_WIDTH).

Verification
REQ-034 SHALL cover: write block 0x40 with words i*3, cycle-0 request -> mem_ready cycle 8; read 0x40 -> mem_hit cycle 2, data words i*3.
REQ-035 SHALL cover: read 0x80 after access to 0x40 -> mem_ready cycle 8, mem_hit never high; row_hit_count unchanged.
REQ-036 SHALL cover: mem_read and mem_write both high at 0x100 -> write occurs; subsequent read returns written data.
REQ-037 SHALL cover: rst_n low at WAIT cycle 4 -> no pulse, outputs zero, open-row invalid; array retains prior data.
REQ-038 SHALL cover: mem_addr changed to 0xC0 during WAIT -> response uses captured 0x40.
REQ-039 SHALL cover: 65540 open-row reads -> access_count and row_hit_count saturate at 16'hFFFF.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default parameter values for the block-memory responder.
// The state enum is common to the responder FSM and any bench that inspects it.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_BLOCK_SIZE   = 16;
    localparam int DEF_MEM_BLOCKS   = 256;
    localparam int DEF_MISS_LATENCY = 8;
    localparam int DEF_HIT_LATENCY  = 2;
    localparam int STAT_W           = 16;

endpackage

// File: rtl/mem_array.sv
// Block storage: one full block written per clock, combinational block read.
// Contents are deliberately not reset.
module mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 16,
    parameter int MEM_BLOCKS = 256,
    parameter int IDX_W      = $clog2(MEM_BLOCKS)
) (
    input  logic                                 clk,
    input  logic                                 i_we,
    input  logic [IDX_W-1:0]                     i_idx,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] i_wdata,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] o_rdata
);

    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_mem [MEM_BLOCKS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Latency-modelling block memory with a single open row: requests hitting the
// open row complete after HIT_LATENCY cycles, all others after MISS_LATENCY.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int BLOCK_SIZE   = DEF_BLOCK_SIZE,
    parameter int MEM_BLOCKS   = DEF_MEM_BLOCKS,
    parameter int MISS_LATENCY = DEF_MISS_LATENCY,
    parameter int HIT_LATENCY  = DEF_HIT_LATENCY
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_WIDTH-1:0]                mem_addr,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in,
    input  logic                                 mem_read,
    input  logic                                 mem_write,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
    output logic                                 mem_ready,
    output logic                                 mem_hit,
    output logic [STAT_W-1:0]                    access_count,
    output logic [STAT_W-1:0]                    row_hit_count
);

    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int IDX_W = $clog2(MEM_BLOCKS);
    localparam int CD_W  = $clog2(MISS_LATENCY + 1);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

    state_t                                r_state;
    state_t                                w_next;
    logic [IDX_W-1:0]                      r_idx;
    logic [IDX_W-1:0]                      r_open_idx;
    logic                                  r_open_vld;
    logic                                  r_is_wr;
    logic                                  r_hit;
    logic [CD_W-1:0]                       r_cnt;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_wdata;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_data_out;
    logic [STAT_W-1:0]                     r_acc_cnt;
    logic [STAT_W-1:0]                     r_hit_cnt;

    logic [IDX_W-1:0]                      w_idx;
    logic [IDX_W-1:0]                      w_arr_idx;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] w_arr_rdata;
    logic                                  w_req;
    logic                                  w_req_hit;
    logic [CD_W-1:0]                       w_lat_m1;
    logic                                  w_op_wr;
    logic                                  w_arr_we;
    logic                                  w_unused;

    assign w_idx     = mem_addr[OFF_W +: IDX_W];
    assign w_unused  = ^mem_addr;
    assign w_req     = mem_read || mem_write;
    assign w_req_hit = r_open_vld && (w_idx == r_open_idx);
    assign w_lat_m1  = w_req_hit ? CD_W'(HIT_LATENCY - 1) : CD_W'(MISS_LATENCY - 1);

    // A latency of 1 enters RESP straight from IDLE, before r_idx holds the
    // request, so the array is addressed from the live bus in that case.
    assign w_arr_idx = (r_state == ST_IDLE) ? w_idx : r_idx;
    assign w_op_wr   = (r_state == ST_IDLE) ? mem_write : r_is_wr;
    assign w_arr_we  = (r_state == ST_RESP) && r_is_wr;

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .MEM_BLOCKS (MEM_BLOCKS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_idx   (w_arr_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_comb begin
        w_next    = r_state;
        mem_ready = 1'b0;
        mem_hit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next = (w_lat_m1 == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= CD_W'(1)) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next    = ST_RECOVER;
                mem_ready = !r_hit;
                mem_hit   = r_hit;
            end
            ST_RECOVER: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_is_wr    <= 1'b0;
            r_hit      <= 1'b0;
            r_cnt      <= '0;
            r_open_vld <= 1'b0;
            r_data_out <= '0;
            r_acc_cnt  <= '0;
            r_hit_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_req) begin
                r_is_wr <= mem_write;
                r_hit   <= w_req_hit;
                r_cnt   <= w_lat_m1;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - CD_W'(1);
            end
            // Read data is latched on entry to RESP and held until the next read.
            if (w_next == ST_RESP && r_state != ST_RESP && !w_op_wr) begin
                r_data_out <= w_arr_rdata;
            end
            if (r_state == ST_RESP) begin
                r_open_vld <= 1'b1;
                r_acc_cnt  <= sat_inc(r_acc_cnt);
                if (r_hit) begin
                    r_hit_cnt <= sat_inc(r_hit_cnt);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && w_req) begin
            r_idx   <= w_idx;
            r_wdata <= mem_data_in;
        end
        if (r_state == ST_RESP) begin
            r_open_idx <= r_idx;
        end
    end

    assign mem_data_out  = r_data_out;
    assign access_count  = r_acc_cnt;
    assign row_hit_count = r_hit_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, open-row classification, data
// path, mid-access reset and statistics saturation.
module tb_mem_responder;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 16;
    localparam int MB = 256;
    localparam int BW = BS * DW;

    typedef logic [BS-1:0][DW-1:0] blk_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    blk_t          mem_data_in = '0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    blk_t          mem_data_out;
    logic          mem_ready;
    logic          mem_hit;
    logic [15:0]   access_count;
    logic [15:0]   row_hit_count;

    int n_checks = 0;
    int n_errors = 0;

    mem_responder #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .BLOCK_SIZE   (BS),
        .MEM_BLOCKS   (MB),
        .MISS_LATENCY (8),
        .HIT_LATENCY  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_data_out  (mem_data_out),
        .mem_ready     (mem_ready),
        .mem_hit       (mem_hit),
        .access_count  (access_count),
        .row_hit_count (row_hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic blk_t make_blk(input logic [31:0] base, input int mul);
        blk_t b;
        for (int i = 0; i < BS; i++) begin
            b[i] = base + 32'(i * mul);
        end
        return b;
    endfunction

    // Issues a request in cycle 0 and measures the cycle of the first pulse.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [AW-1:0] addr, input blk_t data,
                             input int exp_lat, input logic exp_hit,
                             input int chg_cycle, input logic [AW-1:0] alt_addr);
        int   lat;
        logic saw_ready;
        logic saw_hit;
        lat = 0;
        saw_ready = 1'b0;
        saw_hit = 1'b0;
        @(posedge clk); #1;
        mem_addr = addr;
        mem_read = rd;
        mem_write = wr;
        mem_data_in = data;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (mem_ready || mem_hit) begin
                lat = k;
                saw_ready = mem_ready;
                saw_hit = mem_hit;
                break;
            end
            if (k == chg_cycle) begin
                mem_addr = alt_addr;
                mem_data_in = ~data;
            end
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_kind"}, {saw_ready, saw_hit}, exp_hit ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        check({tag, "_onecyc"}, {mem_ready, mem_hit}, 2'b00);
    endtask

    initial begin
        blk_t b3;
        blk_t ba;
        blk_t bx;
        blk_t prev;
        int   pulses;
        int   nhit;
        int   nmiss;

        b3 = make_blk(32'h0, 3);
        ba = make_blk(32'hA000, 1);
        bx = make_blk(32'h5555_0000, 1);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", mem_ready, 0);
        check("rst_hit", mem_hit, 0);
        check("rst_data", mem_data_out, 0);
        check("rst_acc", access_count, 0);
        check("rst_rowhit", row_hit_count, 0);
        rst_n = 1'b1;

        do_access("wr40", 1'b0, 1'b1, 'h40, b3, 8, 1'b0, 0, '0);
        check("wr40_acc", access_count, 1);
        check("wr40_rowhit", row_hit_count, 0);

        do_access("rd40", 1'b1, 1'b0, 'h40, '0, 2, 1'b1, 0, '0);
        check("rd40_data", mem_data_out, b3);
        check("rd40_w5", mem_data_out[5], 15);
        check("rd40_acc", access_count, 2);
        check("rd40_rowhit", row_hit_count, 1);

        do_access("rd80", 1'b1, 1'b0, 'h80, '0, 8, 1'b0, 0, '0);
        check("rd80_acc", access_count, 3);
        check("rd80_rowhit", row_hit_count, 1);

        prev = mem_data_out;
        do_access("rw100", 1'b1, 1'b1, 'h100, ba, 8, 1'b0, 0, '0);
        check("rw100_dout_held", mem_data_out, prev);
        check("rw100_acc", access_count, 4);

        do_access("rd100", 1'b1, 1'b0, 'h100, '0, 2, 1'b1, 0, '0);
        check("rd100_data", mem_data_out, ba);
        check("rd100_rowhit", row_hit_count, 2);

        do_access("rd40chg", 1'b1, 1'b0, 'h40, '0, 8, 1'b0, 3, 'hC0);
        check("rd40chg_data", mem_data_out, b3);
        do_access("rd40again", 1'b1, 1'b0, 'h40, '0, 2, 1'b1, 0, '0);
        check("rd40again_acc", access_count, 7);
        check("rd40again_rowhit", row_hit_count, 3);

        do_access("rd100b", 1'b1, 1'b0, 'h100, '0, 8, 1'b0, 0, '0);
        check("rd100b_data", mem_data_out, ba);

        // Reset arrives in WAIT cycle 4 of a closed-row write to 0x40.
        @(posedge clk); #1;
        mem_addr = 'h40;
        mem_write = 1'b1;
        mem_data_in = bx;
        pulses = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (mem_ready || mem_hit) pulses++;
        end
        rst_n = 1'b0;
        #1;
        mem_write = 1'b0;
        check("midrst_nopulse", pulses, 0);
        check("midrst_ready", mem_ready, 0);
        check("midrst_hit", mem_hit, 0);
        check("midrst_data", mem_data_out, 0);
        check("midrst_acc", access_count, 0);
        check("midrst_rowhit", row_hit_count, 0);
        @(posedge clk); #1;
        check("midrst_held_nopulse", {mem_ready, mem_hit}, 2'b00);
        rst_n = 1'b1;

        do_access("post_rd100", 1'b1, 1'b0, 'h100, '0, 8, 1'b0, 0, '0);
        check("post_rd100_data", mem_data_out, ba);
        do_access("post_rd40", 1'b1, 1'b0, 'h40, '0, 8, 1'b0, 0, '0);
        check("post_rd40_data", mem_data_out, b3);
        check("post_acc", access_count, 2);
        check("post_rowhit", row_hit_count, 0);

        // Back-to-back open-row reads with the request held continuously.
        @(posedge clk); #1;
        mem_addr = 'h40;
        mem_read = 1'b1;
        nhit = 0;
        nmiss = 0;
        for (int c = 0; c < 300000 && nhit < 65540; c++) begin
            @(posedge clk); #1;
            if (mem_hit) nhit++;
            if (mem_ready) nmiss++;
        end
        mem_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sat_hits", nhit, 65540);
        check("sat_misses", nmiss, 0);
        check("sat_acc", access_count, 16'hFFFF);
        check("sat_rowhit", row_hit_count, 16'hFFFF);
        check("sat_data", mem_data_out, b3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
